// File: rtl/bus_timer_if.sv
// ----------------------------------------------------------------------------
// bus_timer_if -- initiator/target bus bundle for bus_timer.
//   dba   [15:0] word/byte address from initiator
//   dbo   [15:0] write data from initiator
//   din          read strobe (held until reply)
//   dout         write strobe (held until reply)
//   wtbt         byte-write qualifier, dba[0] picks the lane
//   dbi   [15:0] read data from target, valid while reply=1
//   reply        transfer acknowledge from target
//   sel          combinational address hit from target
// ----------------------------------------------------------------------------
interface bus_timer_if;
    logic [15:0] dba;
    logic [15:0] dbo;
    logic        din;
    logic        dout;
    logic        wtbt;
    logic [15:0] dbi;
    logic        reply;
    logic        sel;

    modport master (output dba, dbo, din, dout, wtbt, input dbi, reply, sel);
    modport slave  (input dba, dbo, din, dout, wtbt, output dbi, reply, sel);
endinterface

// File: rtl/bus_timer.sv
// ----------------------------------------------------------------------------
// bus_timer -- programmable down-counting interval timer on a strobe bus.
//   Registers: PRESET (BASE), COUNT (BASE+2, read-only), CSR (BASE+4).
//   CSR: bit0 RUN, bit1 ONESHOT, bit2 DIV4, bit3 DIV16, bit6 IE, bit7 DONE.
// Ports:
//   clk      system clock, all state qualified by ce
//   reset_n  asynchronous active-low reset
//   ce       clock enable
//   bus      bus_timer_if slave modport (dba/dbo/din/dout/wtbt in,
//            dbi/reply/sel out)
//   irq      DONE & IE level
// ----------------------------------------------------------------------------
module bus_timer #(
    parameter logic [15:0] BASE     = 16'o177706,
    parameter int unsigned PRESCALE = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    bus_timer_if.slave  bus,
    output logic        irq
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

    localparam logic [14:0] A_PRESET = BASE[15:1];
    localparam logic [14:0] A_COUNT  = BASE[15:1] + 15'd1;
    localparam logic [14:0] A_CSR    = BASE[15:1] + 15'd2;
    localparam logic [15:0] PS_LAST  = 16'(PRESCALE - 1);

    // Merge write data into the old register value according to the byte lane.
    function automatic logic [15:0] f_byte_merge(input logic [15:0] old_v,
                                                 input logic [15:0] data,
                                                 input logic        wtbt,
                                                 input logic        a0);
        if (!wtbt) begin
            return data;
        end else if (a0) begin
            return {data[15:8], old_v[7:0]};
        end else begin
            return {old_v[15:8], data[7:0]};
        end
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_preset;
    logic [15:0] r_count;
    logic        r_run;
    logic        r_oneshot;
    logic        r_div4;
    logic        r_div16;
    logic        r_ie;
    logic        r_done;
    logic [15:0] r_presc;
    logic [5:0]  r_sub;
    logic        r_reply;
    logic [15:0] r_dbi;

    logic        w_hit_preset;
    logic        w_hit_count;
    logic        w_hit_csr;
    logic        w_sel;
    logic [15:0] w_csr;
    logic [15:0] w_rdata;
    logic [15:0] w_wdata;
    logic        w_wr;
    logic        w_preset_wr;
    logic        w_csr_wr;
    logic        w_run_start;
    logic        w_base_tick;
    logic [5:0]  w_sub_mask;
    logic        w_tick;
    logic        w_reply_nxt;
    logic [15:0] w_dbi_nxt;

    assign w_hit_preset = (bus.dba[15:1] == A_PRESET);
    assign w_hit_count  = (bus.dba[15:1] == A_COUNT);
    assign w_hit_csr    = (bus.dba[15:1] == A_CSR);
    // Simultaneous din and dout is not a legal transfer and is never decoded.
    assign w_sel        = (bus.din ^ bus.dout) & (w_hit_preset | w_hit_count | w_hit_csr);
    assign w_csr        = {8'h00, r_done, r_ie, 2'b00, r_div16, r_div4, r_oneshot, r_run};

    // Read-data mux of the addressed register (pre-edge values).
    always_comb begin
        w_rdata = 16'h0000;
        if (w_hit_preset) begin
            w_rdata = r_preset;
        end else if (w_hit_count) begin
            w_rdata = r_count;
        end else if (w_hit_csr) begin
            w_rdata = w_csr;
        end else begin
            w_rdata = 16'h0000;
        end
    end

    // Writes happen only on the IDLE->ACK edge, so a held strobe writes once.
    assign w_wr        = ce & (r_state == ST_IDLE) & w_sel & bus.dout;
    assign w_wdata     = f_byte_merge(w_rdata, bus.dbo, bus.wtbt, bus.dba[0]);
    assign w_preset_wr = w_wr & w_hit_preset;
    assign w_csr_wr    = w_wr & w_hit_csr;
    assign w_run_start = w_csr_wr & w_wdata[0] & ~r_run;

    // Sub-divider free-runs on base ticks; a timer tick is when the selected low bits are all ones.
    always_comb begin
        w_sub_mask = 6'd0;
        case ({r_div16, r_div4})
            2'b00:   w_sub_mask = 6'd0;
            2'b01:   w_sub_mask = 6'd3;
            2'b10:   w_sub_mask = 6'd15;
            2'b11:   w_sub_mask = 6'd63;
            default: w_sub_mask = 6'd0;
        endcase
    end

    assign w_base_tick = r_run & (r_presc == PS_LAST);
    assign w_tick      = w_base_tick & ((r_sub & w_sub_mask) == w_sub_mask);

    // Handshake next-state and registered bus outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_reply_nxt = r_reply;
        w_dbi_nxt   = r_dbi;
        case (r_state)
            ST_IDLE: begin
                if (w_sel) begin
                    w_state_nxt = ST_ACK;
                    w_reply_nxt = 1'b1;
                    w_dbi_nxt   = w_rdata;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!bus.din && !bus.dout) begin
                    w_state_nxt = ST_IDLE;
                    w_reply_nxt = 1'b0;
                    w_dbi_nxt   = 16'h0000;
                end else begin
                    w_state_nxt = ST_ACK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_reply_nxt = 1'b0;
                w_dbi_nxt   = 16'h0000;
            end
        endcase
    end

    // Handshake state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_reply <= 1'b0;
            r_dbi   <= 16'h0000;
        end else if (ce) begin
            r_state <= w_state_nxt;
            r_reply <= w_reply_nxt;
            r_dbi   <= w_dbi_nxt;
        end
    end

    // Timer datapath and registers; bus writes come last so they win over expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_preset  <= 16'h0000;
            r_count   <= 16'h0000;
            r_run     <= 1'b0;
            r_oneshot <= 1'b0;
            r_div4    <= 1'b0;
            r_div16   <= 1'b0;
            r_ie      <= 1'b0;
            r_done    <= 1'b0;
            r_presc   <= 16'h0000;
            r_sub     <= 6'd0;
        end else if (ce) begin
            if (r_run) begin
                r_presc <= w_base_tick ? 16'h0000 : (r_presc + 16'd1);
                if (w_base_tick) begin
                    r_sub <= r_sub + 6'd1;
                end
            end
            if (w_tick) begin
                if (r_count != 16'h0000) begin
                    r_count <= r_count - 16'd1;
                end else begin
                    r_count <= r_preset;
                    r_done  <= 1'b1;
                    if (r_oneshot) begin
                        r_run <= 1'b0;
                    end
                end
            end
            if (w_preset_wr) begin
                r_preset <= w_wdata;
            end
            if (w_csr_wr) begin
                r_run     <= w_wdata[0];
                r_oneshot <= w_wdata[1];
                r_div4    <= w_wdata[2];
                r_div16   <= w_wdata[3];
                r_ie      <= w_wdata[6];
                r_done    <= 1'b0;
                if (w_run_start) begin
                    r_count <= r_preset;
                    r_presc <= 16'h0000;
                end
            end
        end
    end

    assign bus.sel   = w_sel;
    assign bus.reply = r_reply;
    assign bus.dbi   = r_dbi;
    assign irq       = r_done & r_ie;

endmodule

// File: tb/tb_bus_timer.sv
// ----------------------------------------------------------------------------
// tb_bus_timer -- self-checking bench for bus_timer (PRESCALE=4).
// A transfer-level reference model runs beside the DUT and is compared on
// every falling edge; register tables and timing sequences check constants.
// ----------------------------------------------------------------------------
module tb_bus_timer;
    localparam logic [15:0] BASE     = 16'o177706;
    localparam int          PRESCALE = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic ce      = 1'b0;
    logic irq;
    logic mon_en  = 1'b0;
    logic rnd_ce  = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    bus_timer_if bus ();

    bus_timer #(.BASE(BASE), .PRESCALE(PRESCALE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus.slave),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] preset;
        logic [15:0] count;
        logic [15:0] dbi;
        logic        run, one, d4, d16, ie, done, busy, reply;
        int          ps;
        int          sub;
    } mstate_t;

    mstate_t m;

    // Register index 0..2 for a legal single-strobe access, else -1.
    function automatic int reg_index(input logic [15:0] a, input logic r, input logic w);
        int off;
        if (r == w) return -1;
        off = int'(a[15:1]) - int'(BASE[15:1]);
        if (off >= 0 && off <= 2) return off;
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic c, input logic [15:0] a,
                                           input logic [15:0] d, input logic r, input logic w,
                                           input logic bw);
        mstate_t     n = s;
        int          off;
        int          div;
        logic        tick = 1'b0;
        logic [15:0] rdv;
        logic [15:0] wv;
        if (!c) return s;
        off = reg_index(a, r, w);
        rdv = (off == 0) ? s.preset : (off == 1) ? s.count :
              {8'h00, s.done, s.ie, 2'b00, s.d16, s.d4, s.one, s.run};
        if (s.run) begin
            n.ps = s.ps + 1;
            if (n.ps == PRESCALE) begin
                n.ps  = 0;
                div   = (s.d4 ? 4 : 1) * (s.d16 ? 16 : 1);
                tick  = ((s.sub % div) == div - 1);
                n.sub = (s.sub + 1) % 64;
            end
        end
        if (tick) begin
            if (s.count != 16'h0000) begin
                n.count = s.count - 16'd1;
            end else begin
                n.count = s.preset;
                n.done  = 1'b1;
                if (s.one) n.run = 1'b0;
            end
        end
        if (!s.busy && off >= 0 && w) begin
            if (!bw)      wv = d;
            else if (a[0]) wv = {d[15:8], rdv[7:0]};
            else          wv = {rdv[15:8], d[7:0]};
            if (off == 0) begin
                n.preset = wv;
            end else if (off == 2) begin
                n.run  = wv[0];
                n.one  = wv[1];
                n.d4   = wv[2];
                n.d16  = wv[3];
                n.ie   = wv[6];
                n.done = 1'b0;
                if (wv[0] && !s.run) begin
                    n.count = s.preset;
                    n.ps    = 0;
                end
            end
        end
        if (!s.busy && off >= 0) begin
            n.busy  = 1'b1;
            n.reply = 1'b1;
            n.dbi   = rdv;
        end else if (s.busy && !r && !w) begin
            n.busy  = 1'b0;
            n.reply = 1'b0;
            n.dbi   = 16'h0000;
        end
        return n;
    endfunction

    // Model state advances on the same edges as the DUT.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else          m <= model_next(m, ce, bus.dba, bus.dbo, bus.din, bus.dout, bus.wtbt);
    end

    // Continuous comparison away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mdl_reply", {15'd0, bus.reply}, {15'd0, m.reply});
            check("mdl_dbi", bus.dbi, m.dbi);
            check("mdl_irq", {15'd0, irq}, {15'd0, m.done & m.ie});
            check("mdl_sel", {15'd0, bus.sel},
                  {15'd0, reg_index(bus.dba, bus.din, bus.dout) >= 0});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(negedge clk);
        #1;
        if (rnd_ce) ce = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) nxt();
    endtask

    task automatic xfer(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic bw, output logic [15:0] rd);
        int n;
        bus.dba  = a;
        bus.dbo  = d;
        bus.wtbt = bw;
        bus.din  = ~wr;
        bus.dout = wr;
        n = 0;
        nxt();
        while (!bus.reply && n < 200) begin nxt(); n++; end
        check("reply_rise", {15'd0, bus.reply}, 16'd1);
        rd       = bus.dbi;
        bus.din  = 1'b0;
        bus.dout = 1'b0;
        n = 0;
        nxt();
        while (bus.reply && n < 200) begin nxt(); n++; end
        check("reply_fall", {15'd0, bus.reply}, 16'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic        bw;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    vec_t tv [14];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [15:0] rd;
        int          k;
        logic [15:0] a;
        tv[0]  = '{1'b1, 16'o177706, 16'o000005, 1'b0, 1'b0, 16'h0000};
        tv[1]  = '{1'b0, 16'o177706, 16'h0000,   1'b0, 1'b1, 16'h0005};
        tv[2]  = '{1'b1, 16'o177707, 16'hFF00,   1'b1, 1'b0, 16'h0000};
        tv[3]  = '{1'b0, 16'o177706, 16'h0000,   1'b0, 1'b1, 16'hFF05};
        tv[4]  = '{1'b1, 16'o177710, 16'h7777,   1'b0, 1'b0, 16'h0000};
        tv[5]  = '{1'b0, 16'o177710, 16'h0000,   1'b0, 1'b1, 16'h0000};
        tv[6]  = '{1'b1, 16'o177706, 16'h12AB,   1'b1, 1'b0, 16'h0000};
        tv[7]  = '{1'b0, 16'o177706, 16'h0000,   1'b0, 1'b1, 16'hFFAB};
        tv[8]  = '{1'b1, 16'o177707, 16'h1234,   1'b0, 1'b0, 16'h0000};
        tv[9]  = '{1'b0, 16'o177707, 16'h0000,   1'b0, 1'b1, 16'h1234};
        tv[10] = '{1'b1, 16'o177712, 16'h00FC,   1'b0, 1'b0, 16'h0000};
        tv[11] = '{1'b0, 16'o177712, 16'h0000,   1'b0, 1'b1, 16'h004C};
        tv[12] = '{1'b1, 16'o177712, 16'hFF00,   1'b0, 1'b0, 16'h0000};
        tv[13] = '{1'b0, 16'o177712, 16'h0000,   1'b0, 1'b1, 16'h0000};

        bus.dba = 16'h0000; bus.dbo = 16'h0000;
        bus.din = 1'b0; bus.dout = 1'b0; bus.wtbt = 1'b0;
        idle(2);
        mon_en = 1'b1;
        check("rst_reply", {15'd0, bus.reply}, 16'd0);
        check("rst_dbi", bus.dbi, 16'h0000);
        check("rst_irq", {15'd0, irq}, 16'd0);
        reset_n = 1'b1;
        ce      = 1'b1;
        idle(1);

        // register access table
        for (int i = 0; i < 14; i++) begin
            xfer(tv[i].wr, tv[i].a, tv[i].d, tv[i].bw, rd);
            if (tv[i].chk) check($sformatf("tbl%0d", i), rd, tv[i].exp);
        end

        // exact reply timing on a word write then read
        xfer(1'b1, 16'o177706, 16'o000005, 1'b0, rd);
        bus.dba = 16'o177706; bus.din = 1'b1;
        check("t_reply_pre", {15'd0, bus.reply}, 16'd0);
        nxt();
        check("t_reply_1cyc", {15'd0, bus.reply}, 16'd1);
        check("t_dbi", bus.dbi, 16'o000005);
        idle(2);
        check("t_reply_held", {15'd0, bus.reply}, 16'd1);
        bus.din = 1'b0;
        nxt();
        check("t_reply_drop", {15'd0, bus.reply}, 16'd0);
        check("t_dbi_clr", bus.dbi, 16'h0000);

        // periodic countdown with reload
        xfer(1'b1, 16'o177706, 16'd3, 1'b0, rd);
        xfer(1'b1, 16'o177712, 16'o000001, 1'b0, rd);
        for (int i = 3; i >= 0; i--) begin
            xfer(1'b0, 16'o177710, 16'h0000, 1'b0, rd);
            check($sformatf("cnt_%0d", i), rd, 16'(i));
            idle(2);
        end
        xfer(1'b0, 16'o177710, 16'h0000, 1'b0, rd);
        check("cnt_reload", rd, 16'd3);
        xfer(1'b0, 16'o177712, 16'h0000, 1'b0, rd);
        check("csr_done", rd, 16'o000201);
        check("irq_masked", {15'd0, irq}, 16'd0);
        xfer(1'b1, 16'o177712, 16'h0000, 1'b0, rd);

        // one-shot with interrupt
        xfer(1'b1, 16'o177706, 16'd2, 1'b0, rd);
        xfer(1'b1, 16'o177712, 16'o000103, 1'b0, rd);
        idle(12);
        check("os_irq", {15'd0, irq}, 16'd1);
        xfer(1'b0, 16'o177712, 16'h0000, 1'b0, rd);
        check("os_csr", rd, 16'o000302);
        xfer(1'b0, 16'o177710, 16'h0000, 1'b0, rd);
        check("os_count", rd, 16'd2);
        idle(8);
        xfer(1'b0, 16'o177710, 16'h0000, 1'b0, rd);
        check("os_hold", rd, 16'd2);
        xfer(1'b1, 16'o177712, 16'h0000, 1'b0, rd);
        check("os_irq_clr", {15'd0, irq}, 16'd0);

        // CSR write on the same edge as an expiry
        xfer(1'b1, 16'o177706, 16'd0, 1'b0, rd);
        xfer(1'b1, 16'o177712, 16'o000001, 1'b0, rd);
        idle(4);
        xfer(1'b0, 16'o177712, 16'h0000, 1'b0, rd);
        check("p0_done", rd, 16'o000201);
        xfer(1'b1, 16'o177712, 16'o000001, 1'b0, rd);
        xfer(1'b0, 16'o177712, 16'h0000, 1'b0, rd);
        check("wr_wins", rd, 16'o000001);

        // both strobes: no reply, no write
        bus.dba = 16'o177712; bus.dbo = 16'h0000; bus.din = 1'b1; bus.dout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            nxt();
            check("both_noreply", {15'd0, bus.reply}, 16'd0);
        end
        bus.din = 1'b0; bus.dout = 1'b0;
        nxt();
        xfer(1'b0, 16'o177712, 16'h0000, 1'b0, rd);
        check("both_nowrite", {15'd0, rd[0]}, 16'd1);
        xfer(1'b1, 16'o177712, 16'h0000, 1'b0, rd);

        // reset during ACK, strobe still held afterwards
        xfer(1'b1, 16'o177706, 16'h0042, 1'b0, rd);
        bus.dba = 16'o177706; bus.din = 1'b1;
        nxt();
        check("ra_reply", {15'd0, bus.reply}, 16'd1);
        #2 reset_n = 1'b0;
        #1;
        check("ra_reply_now", {15'd0, bus.reply}, 16'd0);
        check("ra_dbi_now", bus.dbi, 16'h0000);
        nxt();
        reset_n = 1'b1;
        nxt();
        check("ra_new_xfer", {15'd0, bus.reply}, 16'd1);
        check("ra_preset_clr", bus.dbi, 16'h0000);
        bus.din = 1'b0;
        idle(2);

        // randomized traffic against the model
        rnd_ce = 1'b1;
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 19);
            a = BASE + 16'(2 * $urandom_range(0, 2)) + 16'($urandom_range(0, 1));
            if (k < 7) begin
                xfer(1'b0, a, 16'h0000, 1'b0, rd);
            end else if (k < 11) begin
                xfer(1'b1, BASE, 16'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), rd);
            end else if (k < 14) begin
                xfer(1'b1, BASE + 16'd4, 16'($urandom) & 16'h00FF, 1'($urandom_range(0, 1)), rd);
            end else if (k == 14) begin
                xfer(1'b1, a, 16'($urandom), 1'($urandom_range(0, 1)), rd);
            end else if (k == 15) begin
                bus.dba = ($urandom_range(0, 1) != 0) ? a : (BASE + 16'd6);
                bus.dbo = 16'($urandom);
                bus.din = 1'b1;
                bus.dout = 1'($urandom_range(0, 1));
                idle($urandom_range(1, 4));
                bus.din = 1'b0; bus.dout = 1'b0;
                idle(1);
            end else if (k == 16 && $urandom_range(0, 9) == 0) begin
                #2 reset_n = 1'b0;
                nxt();
                reset_n = 1'b1;
                nxt();
            end else begin
                idle($urandom_range(0, 10));
            end
        end
        rnd_ce = 1'b0;
        ce     = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
